movseq_dispenser: RTL and testbench

Consumer-side partner of the restricted move-sequence generator. It accepts 8-bit bags: permutations of the four 2-bit symbols, packed low bits first. It buffers up to two bags and dispenses them one symbol per handshake. It feeds the last symbol of the most recently accepted bag back as the generator's restricted input. It also rejects malformed bags and counts head repeats, so the generator's bias can be observed at run time.

---
 rtl/movseq_pkg.sv | 25 ++
 rtl/movseq_dispenser_bag_perm_check.sv | 28 ++
 rtl/movseq_dispenser.sv | 139 +++++++++++++
 tb/tb_movseq_dispenser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/movseq_pkg.sv
// Shared definitions for the move-sequence dispenser.
//
// Contents:
//   SYM_W, BAG_W, NSYM  - symbol width, bag width, symbols per bag
//   buf_state_t         - occupancy of the two-bag buffer
//   get_sym(bag, idx)   - extract symbol idx from a packed bag (symbol 0 in the low bits)
package movseq_pkg;

    localparam int SYM_W = 2;
    localparam int BAG_W = 8;
    localparam int NSYM  = 4;

    // EMPTY: nothing buffered, ONE: only cur holds a bag, FULL: cur and nxt both hold bags.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    function automatic logic [SYM_W-1:0] get_sym(input logic [BAG_W-1:0] bag,
                                                 input logic [1:0]       idx);
        return bag[SYM_W*idx +: SYM_W];
    endfunction

endpackage

// File: rtl/movseq_dispenser_bag_perm_check.sv
// bag_perm_check: combinational check that a bag is a permutation of the
// four 2-bit symbols. It is also used on its own by the generator bench.
//
// Ports:
//   seq_in  in  8  packed bag, symbol k in bits [2k+1:2k]
//   is_perm out 1  high when all four symbols are distinct
module bag_perm_check
    import movseq_pkg::*;
(
    input  logic [BAG_W-1:0] seq_in,
    output logic             is_perm
);

    logic [SYM_W-1:0] sym [NSYM];

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_split
            assign sym[gi] = seq_in[SYM_W*gi +: SYM_W];
        end
    endgenerate

    // Four values drawn from a four-symbol alphabet are a permutation
    // exactly when no two of them are equal.
    assign is_perm = (sym[0] != sym[1]) && (sym[0] != sym[2]) && (sym[0] != sym[3]) &&
                     (sym[1] != sym[2]) && (sym[1] != sym[3]) &&
                     (sym[2] != sym[3]);

endmodule

// File: rtl/movseq_dispenser.sv
// movseq_dispenser: accepts 8-bit bags (permutations of four 2-bit symbols)
// from the move-sequence generator, buffers up to two of them and hands them
// out one symbol per handshake, symbol 0 first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   seq_in/seq_valid  bag from the generator
//   seq_ready         bag accepted this cycle (high unless both slots are occupied)
//   restricted        last symbol of the most recently accepted valid bag
//   sym_out/sym_valid current symbol offered to the consumer
//   sym_ready         consumer takes sym_out
//   perm_err          sticky flag: a malformed bag arrived
//   repeat_cnt        saturating count of bags whose head equals the previous tail
module movseq_dispenser
    import movseq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BAG_W-1:0] seq_in,
    input  logic             seq_valid,
    output logic             seq_ready,
    output logic [SYM_W-1:0] restricted,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             perm_err,
    output logic [CNT_W-1:0] repeat_cnt
);

    buf_state_t       state_reg;
    logic [BAG_W-1:0] cur_bag_reg;
    logic [1:0]       cur_idx_reg;
    logic [BAG_W-1:0] nxt_bag_reg;
    logic [SYM_W-1:0] restricted_reg;
    logic             perm_err_reg;
    logic [CNT_W-1:0] repeat_cnt_reg;
    logic             first_reg;

    logic is_perm;
    logic accept;
    logic load;
    logic pop;
    logic pop_last;
    logic head_repeat;

    bag_perm_check u_perm_check (
        .seq_in  (seq_in),
        .is_perm (is_perm)
    );

    // All outputs come straight from registers; seq_valid, seq_in and
    // sym_ready only reach state through the clocked block below.
    assign seq_ready  = (state_reg != FULL);
    assign sym_valid  = (state_reg != EMPTY);
    assign sym_out    = get_sym(cur_bag_reg, cur_idx_reg);
    assign restricted = restricted_reg;
    assign perm_err   = perm_err_reg;
    assign repeat_cnt = repeat_cnt_reg;

    // A malformed bag still completes its handshake but is never loaded.
    assign accept   = seq_valid && seq_ready;
    assign load     = accept && is_perm;
    assign pop      = sym_valid && sym_ready;
    assign pop_last = pop && (cur_idx_reg == 2'd3);

    // The very first bag after reset has no predecessor, so it never counts.
    assign head_repeat = !first_reg && (seq_in[SYM_W-1:0] == restricted_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= EMPTY;
            cur_bag_reg    <= '0;
            cur_idx_reg    <= '0;
            nxt_bag_reg    <= '0;
            restricted_reg <= '0;
            perm_err_reg   <= 1'b0;
            repeat_cnt_reg <= '0;
            first_reg      <= 1'b1;
        end else begin
            if (accept && !is_perm) begin
                perm_err_reg <= 1'b1;
            end

            if (load) begin
                restricted_reg <= seq_in[BAG_W-1 -: SYM_W];
                first_reg      <= 1'b0;
                if (head_repeat && (repeat_cnt_reg != {CNT_W{1'b1}})) begin
                    repeat_cnt_reg <= repeat_cnt_reg + 1'b1;
                end
            end

            case (state_reg)
                EMPTY: begin
                    if (load) begin
                        cur_bag_reg <= seq_in;
                        cur_idx_reg <= '0;
                        state_reg   <= ONE;
                    end
                end
                ONE: begin
                    if (pop_last) begin
                        // The slot frees up this very cycle, so an incoming
                        // bag goes straight into cur and dispensing continues
                        // without a bubble.
                        cur_idx_reg <= '0;
                        if (load) begin
                            cur_bag_reg <= seq_in;
                        end else begin
                            state_reg <= EMPTY;
                        end
                    end else begin
                        if (pop) begin
                            cur_idx_reg <= cur_idx_reg + 2'd1;
                        end
                        if (load) begin
                            nxt_bag_reg <= seq_in;
                            state_reg   <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (pop_last) begin
                        cur_bag_reg <= nxt_bag_reg;
                        cur_idx_reg <= '0;
                        state_reg   <= ONE;
                    end else if (pop) begin
                        cur_idx_reg <= cur_idx_reg + 2'd1;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_movseq_dispenser.sv
module tb_movseq_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seq_in;
    logic       seq_valid;
    logic       seq_ready;
    logic [1:0] restricted;
    logic [1:0] sym_out;
    logic       sym_valid;
    logic       sym_ready;
    logic       perm_err;
    logic [7:0] repeat_cnt;

    int errors = 0;
    int checks = 0;

    movseq_dispenser #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .seq_in     (seq_in),
        .seq_valid  (seq_valid),
        .seq_ready  (seq_ready),
        .restricted (restricted),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .perm_err   (perm_err),
        .repeat_cnt (repeat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: a queue of whole bags ----------------
    logic [7:0] m_q[$];
    int         m_idx;
    logic [1:0] m_restr;
    int         m_cnt;
    bit         m_perr;
    bit         m_first;

    function automatic bit m_is_perm(input logic [7:0] b);
        logic [3:0] seen;
        seen = 4'h0;
        for (int k = 0; k < 4; k++) seen[b[2*k +: 2]] = 1'b1;
        return seen == 4'hF;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idx   = 0;
        m_restr = 2'd0;
        m_cnt   = 0;
        m_perr  = 1'b0;
        m_first = 1'b1;
    endtask

    // One clock edge: the consumer takes a symbol if one is on offer, and a bag
    // is taken if fewer than two were held before the edge.
    task automatic model_step(input bit v, input logic [7:0] s, input bit r);
        bit room;
        room = (m_q.size() < 2);
        if (m_q.size() > 0 && r) begin
            m_idx++;
            if (m_idx == 4) begin
                void'(m_q.pop_front());
                m_idx = 0;
            end
        end
        if (v && room) begin
            if (m_is_perm(s)) begin
                if (!m_first && s[1:0] == m_restr && m_cnt < 255) m_cnt++;
                m_restr = s[7:6];
                m_first = 1'b0;
                m_q.push_back(s);
                $display("[%0t] bag %02h accepted, restricted=%0d repeats=%0d", $time, s, m_restr, m_cnt);
            end else begin
                m_perr = 1'b1;
                $display("[%0t] bag %02h dropped as malformed", $time, s);
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [7:0] hb;
        chk("seq_ready", 32'(seq_ready), 32'(m_q.size() < 2));
        chk("sym_valid", 32'(sym_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            hb = m_q[0];
            chk("sym_out", 32'(sym_out), 32'(hb[2*m_idx +: 2]));
        end
        chk("restricted", 32'(restricted), 32'(m_restr));
        chk("perm_err", 32'(perm_err), 32'(m_perr));
        chk("repeat_cnt", 32'(repeat_cnt), 32'(m_cnt));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_seq_ready"}, 32'(seq_ready), 32'd1);
        chk({tag, "_sym_valid"}, 32'(sym_valid), 32'd0);
        chk({tag, "_sym_out"}, 32'(sym_out), 32'd0);
        chk({tag, "_restricted"}, 32'(restricted), 32'd0);
        chk({tag, "_perm_err"}, 32'(perm_err), 32'd0);
        chk({tag, "_repeat_cnt"}, 32'(repeat_cnt), 32'd0);
    endtask

    // Called just after a falling edge: drive, clock, then compare at the next falling edge.
    task automatic cycle(input bit v, input logic [7:0] s, input bit r);
        seq_valid = v;
        seq_in    = s;
        sym_ready = r;
        @(posedge clk);
        model_step(v, s, r);
        @(negedge clk);
        check_model();
    endtask

    // Reset is held through one edge while a handshake is also offered,
    // so reset priority is exercised every time.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        seq_valid = 1'b1;
        seq_in    = 8'hE4;
        sym_ready = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        seq_valid = 1'b0;
        sym_ready = 1'b0;
        check_reset_values(tag);
    endtask

    function automatic logic [7:0] rand_perm();
        logic [1:0] a[4];
        logic [1:0] t;
        int j;
        for (int k = 0; k < 4; k++) a[k] = 2'(k);
        for (int k = 3; k > 0; k--) begin
            j    = $urandom_range(0, k);
            t    = a[k];
            a[k] = a[j];
            a[j] = t;
        end
        return {a[3], a[2], a[1], a[0]};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         v;
        logic [7:0] s;
        bit         r;
        bit         e_sv;
        logic [1:0] e_sym;
        bit         e_rdy;
        logic [1:0] e_restr;
        int         e_cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [1:0] exp1b[4];
        int acc;
        int budget;
        logic [7:0] bag;

        rst       = 1'b1;
        seq_valid = 1'b0;
        seq_in    = 8'h00;
        sym_ready = 1'b0;

        // 0xE4 (0,1,2,3) then 0x93 (3,0,1,2) back to back, consumer always ready.
        tbl[0] = '{1'b1, 8'hE4, 1'b1, 1'b1, 2'd0, 1'b1, 2'd3, 0};
        tbl[1] = '{1'b1, 8'h93, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b0, 2'd2, 1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1};

        @(negedge clk);
        do_reset("reset0");

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].r);
            chk($sformatf("tbl%0d_sym_valid", i), 32'(sym_valid), 32'(tbl[i].e_sv));
            if (tbl[i].e_sv) chk($sformatf("tbl%0d_sym_out", i), 32'(sym_out), 32'(tbl[i].e_sym));
            chk($sformatf("tbl%0d_seq_ready", i), 32'(seq_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_restricted", i), 32'(restricted), 32'(tbl[i].e_restr));
            chk($sformatf("tbl%0d_repeat_cnt", i), 32'(repeat_cnt), 32'(tbl[i].e_cnt));
        end

        // Consumer stalled while three bags are offered: only two fit.
        do_reset("reset1");
        cycle(1'b1, 8'hE4, 1'b0);
        cycle(1'b1, 8'h93, 1'b0);
        cycle(1'b1, 8'h1B, 1'b0);
        chk("stall_seq_ready", 32'(seq_ready), 32'd0);
        chk("stall_sym_out", 32'(sym_out), 32'd0);
        chk("stall_restricted", 32'(restricted), 32'd2);
        cycle(1'b1, 8'h1B, 1'b0);
        chk("stall_hold_sym_out", 32'(sym_out), 32'd0);
        chk("stall_hold_sym_valid", 32'(sym_valid), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("drain_sym_valid", 32'(sym_valid), 32'd0);

        // Malformed bag is dropped; the following good bag dispenses normally.
        cycle(1'b1, 8'h00, 1'b0);
        chk("bad_perm_err", 32'(perm_err), 32'd1);
        chk("bad_sym_valid", 32'(sym_valid), 32'd0);
        chk("bad_restricted", 32'(restricted), 32'd2);
        exp1b = '{2'd3, 2'd2, 2'd1, 2'd0};
        cycle(1'b1, 8'h1B, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bag1b_sym%0d", i), 32'(sym_out), 32'(exp1b[i]));
            chk($sformatf("bag1b_perm_err%0d", i), 32'(perm_err), 32'd1);
            cycle(1'b0, 8'h00, 1'b1);
        end

        // Last symbol pops while a new bag arrives in the one-bag state.
        do_reset("reset2");
        cycle(1'b1, 8'hE4, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("swap_pre_sym_out", 32'(sym_out), 32'd3);
        cycle(1'b1, 8'h1B, 1'b1);
        chk("swap_sym_valid", 32'(sym_valid), 32'd1);
        chk("swap_sym_out", 32'(sym_out), 32'd3);
        chk("swap_seq_ready", 32'(seq_ready), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("swap_next_sym_out", 32'(sym_out), 32'd2);

        // 260 alternating head-repeat bags: 0xE4 (0..3) and 0x27 (3,1,2,0).
        do_reset("reset3");
        acc    = 0;
        budget = 0;
        while (acc < 260 && budget < 3000) begin
            bag = acc[0] ? 8'h27 : 8'hE4;
            if (m_q.size() < 2) acc++;
            cycle(1'b1, bag, 1'b1);
            budget++;
        end
        chk("sat_accepted", 32'(acc), 32'd260);
        chk("sat_repeat_cnt", 32'(repeat_cnt), 32'd255);

        // Reset in the middle of a bag.
        cycle(1'b0, 8'h00, 1'b1);
        do_reset("reset_mid");

        // Randomized traffic against the model, with one reset half way.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset("reset_rand");
            bag = ($urandom_range(0, 15) == 0) ? 8'($urandom) : rand_perm();
            cycle(1'($urandom_range(0, 1)), bag, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
